rename_unit: RTL and testbench

Four-wide register-rename stage for the out-of-order RV64 core, placed between decode and dispatch. Each clock edge it renames one group of up to four decoded instructions in program order (instr0 oldest). It maps architectural source and destination registers to physical registers through a Register Alias Table (RAT) and a free-list allocator. Dependences inside the group (RAW, WAW, WAR) are resolved by intra-group bypass.

---
 rtl/rename_if.sv | 40 ++++
 rtl/rename_unit.sv | 121 ++++++++++++
 tb/tb_rename_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_if.sv
// rename_if: decode -> rename -> dispatch bundle for one four-wide group.
//   master : decode/dispatch side; drives architectural indices and valid
//            masks, receives renamed physical indices.
//   slave  : rename unit; consumes the group, returns prs1/prs2/prd/preprd.
interface rename_if #(
    parameter int ARF_WIDTH  = 5,
    parameter int PRF_WIDTH  = 6,
    parameter int DECODE_NUM = 4
);
    logic [ARF_WIDTH-1:0]  instr0_rs1, instr0_rs2, instr0_rd;
    logic [ARF_WIDTH-1:0]  instr1_rs1, instr1_rs2, instr1_rd;
    logic [ARF_WIDTH-1:0]  instr2_rs1, instr2_rs2, instr2_rd;
    logic [ARF_WIDTH-1:0]  instr3_rs1, instr3_rs2, instr3_rd;
    logic [DECODE_NUM-1:0] instr_prs1_v, instr_prs2_v, instr_prd_v;

    logic [PRF_WIDTH-1:0]  instr0_prs1, instr0_prs2, instr0_prd, instr0_preprd;
    logic [PRF_WIDTH-1:0]  instr1_prs1, instr1_prs2, instr1_prd, instr1_preprd;
    logic [PRF_WIDTH-1:0]  instr2_prs1, instr2_prs2, instr2_prd, instr2_preprd;
    logic [PRF_WIDTH-1:0]  instr3_prs1, instr3_prs2, instr3_prd, instr3_preprd;

    modport master (
        output instr0_rs1, instr0_rs2, instr0_rd, instr1_rs1, instr1_rs2, instr1_rd,
               instr2_rs1, instr2_rs2, instr2_rd, instr3_rs1, instr3_rs2, instr3_rd,
               instr_prs1_v, instr_prs2_v, instr_prd_v,
        input  instr0_prs1, instr0_prs2, instr0_prd, instr0_preprd,
               instr1_prs1, instr1_prs2, instr1_prd, instr1_preprd,
               instr2_prs1, instr2_prs2, instr2_prd, instr2_preprd,
               instr3_prs1, instr3_prs2, instr3_prd, instr3_preprd
    );

    modport slave (
        input  instr0_rs1, instr0_rs2, instr0_rd, instr1_rs1, instr1_rs2, instr1_rd,
               instr2_rs1, instr2_rs2, instr2_rd, instr3_rs1, instr3_rs2, instr3_rd,
               instr_prs1_v, instr_prs2_v, instr_prd_v,
        output instr0_prs1, instr0_prs2, instr0_prd, instr0_preprd,
               instr1_prs1, instr1_prs2, instr1_prd, instr1_preprd,
               instr2_prs1, instr2_prs2, instr2_prd, instr2_preprd,
               instr3_prs1, instr3_prs2, instr3_prd, instr3_preprd
    );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: four-wide register rename stage between decode and dispatch.
// Renames one group per rising edge through a RAT and a circular free list,
// with intra-group bypass for RAW/WAW/WAR. All outputs are registered
// (1-cycle latency).
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (identity RAT, fl_head = 0, outputs 0)
//   rif   : rename_if.slave carrying the group inputs and renamed outputs
module rename_unit #(
    parameter int ARF_WIDTH  = 5,
    parameter int PRF_WIDTH  = 6,
    parameter int DECODE_NUM = 4
) (
    input logic     clk,
    input logic     rst,
    rename_if.slave rif
);
    localparam int NUM_ARCH = 1 << ARF_WIDTH;
    localparam int N        = DECODE_NUM;

    typedef logic [ARF_WIDTH-1:0] areg_t;
    typedef logic [PRF_WIDTH-1:0] preg_t;

    areg_t rs1 [N];
    areg_t rs2 [N];
    areg_t rd  [N];

    assign rs1[0] = rif.instr0_rs1;  assign rs2[0] = rif.instr0_rs2;  assign rd[0] = rif.instr0_rd;
    assign rs1[1] = rif.instr1_rs1;  assign rs2[1] = rif.instr1_rs2;  assign rd[1] = rif.instr1_rd;
    assign rs1[2] = rif.instr2_rs1;  assign rs2[2] = rif.instr2_rs2;  assign rd[2] = rif.instr2_rd;
    assign rs1[3] = rif.instr3_rs1;  assign rs2[3] = rif.instr3_rs2;  assign rd[3] = rif.instr3_rd;

    preg_t  rat_q [NUM_ARCH];
    preg_t  rat_d [NUM_ARCH];
    areg_t  fl_head_q, fl_head_d;
    preg_t  prs1_q [N], prs1_d [N];
    preg_t  prs2_q [N], prs2_d [N];
    preg_t  prd_q  [N], prd_d  [N];
    preg_t  preprd_q [N], preprd_d [N];
    logic [N-1:0] alloc;
    areg_t  slot;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        rat_d     = rat_q;
        fl_head_d = fl_head_q;
        alloc     = '0;
        slot      = fl_head_q;
        for (int k = 0; k < N; k++) begin
            prs1_d[k]   = '0;
            prs2_d[k]   = '0;
            prd_d[k]    = '0;
            preprd_d[k] = '0;
        end

        // Allocation. The free list never receives returned registers here,
        // so entry i always holds P(NUM_ARCH + i); only the head pointer is state.
        for (int k = 0; k < N; k++) begin
            alloc[k] = rif.instr_prd_v[k] && (rd[k] != '0);
            if (alloc[k]) begin
                prd_d[k] = preg_t'(NUM_ARCH) + preg_t'(slot);
                slot     = slot + areg_t'(1);
            end
        end
        fl_head_d = slot;

        // Sources and previous mapping: start from the RAT, then let each older
        // allocating writer in the group override; ascending j leaves the youngest.
        for (int k = 0; k < N; k++) begin
            prs1_d[k] = rat_q[rs1[k]];
            prs2_d[k] = rat_q[rs2[k]];
            if (alloc[k]) preprd_d[k] = rat_q[rd[k]];
            for (int j = 0; j < k; j++) begin
                if (alloc[j] && rd[j] == rs1[k]) prs1_d[k] = prd_d[j];
                if (alloc[j] && rd[j] == rs2[k]) prs2_d[k] = prd_d[j];
                if (alloc[j] && alloc[k] && rd[j] == rd[k]) preprd_d[k] = prd_d[j];
            end
            if (!rif.instr_prs1_v[k] || rs1[k] == '0) prs1_d[k] = '0;
            if (!rif.instr_prs2_v[k] || rs2[k] == '0) prs2_d[k] = '0;
        end

        // Later writes overwrite earlier ones, so the youngest writer wins.
        for (int k = 0; k < N; k++) begin
            if (alloc[k]) rat_d[rd[k]] = prd_d[k];
        end
        rat_d[0] = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the RAT is a flop array, not a RAM, so each entry can and
            // must be reset: the identity mapping is architecturally visible.
            for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= preg_t'(i);
            fl_head_q <= '0;
            for (int k = 0; k < N; k++) begin
                prs1_q[k]   <= '0;
                prs2_q[k]   <= '0;
                prd_q[k]    <= '0;
                preprd_q[k] <= '0;
            end
        end else begin
            rat_q     <= rat_d;
            fl_head_q <= fl_head_d;
            prs1_q    <= prs1_d;
            prs2_q    <= prs2_d;
            prd_q     <= prd_d;
            preprd_q  <= preprd_d;
        end
    end

    assign rif.instr0_prs1 = prs1_q[0];  assign rif.instr0_prs2 = prs2_q[0];
    assign rif.instr1_prs1 = prs1_q[1];  assign rif.instr1_prs2 = prs2_q[1];
    assign rif.instr2_prs1 = prs1_q[2];  assign rif.instr2_prs2 = prs2_q[2];
    assign rif.instr3_prs1 = prs1_q[3];  assign rif.instr3_prs2 = prs2_q[3];
    assign rif.instr0_prd  = prd_q[0];   assign rif.instr0_preprd = preprd_q[0];
    assign rif.instr1_prd  = prd_q[1];   assign rif.instr1_preprd = preprd_q[1];
    assign rif.instr2_prd  = prd_q[2];   assign rif.instr2_preprd = preprd_q[2];
    assign rif.instr3_prd  = prd_q[3];   assign rif.instr3_preprd = preprd_q[3];
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: drives directed and random rename groups into rename_unit
// and compares every output against a reference model that renames the
// instructions one at a time in program order with a running RAT.
module tb_rename_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rename_if rif ();
    rename_unit dut (.clk(clk), .rst(rst), .rif(rif.slave));

    int checks   = 0;
    int failures = 0;

    // Group being presented.
    logic [4:0] g_rs1 [4], g_rs2 [4], g_rd [4];
    logic [3:0] g_v1, g_v2, g_vd;

    // Expected outputs and model state.
    logic [5:0] e_prs1 [4], e_prs2 [4], e_prd [4], e_preprd [4];
    int m_rat [32];
    int m_head;

    // DUT outputs gathered into arrays.
    logic [5:0] o_prs1 [4], o_prs2 [4], o_prd [4], o_preprd [4];
    assign o_prs1[0] = rif.instr0_prs1;  assign o_prs2[0] = rif.instr0_prs2;
    assign o_prs1[1] = rif.instr1_prs1;  assign o_prs2[1] = rif.instr1_prs2;
    assign o_prs1[2] = rif.instr2_prs1;  assign o_prs2[2] = rif.instr2_prs2;
    assign o_prs1[3] = rif.instr3_prs1;  assign o_prs2[3] = rif.instr3_prs2;
    assign o_prd[0]  = rif.instr0_prd;   assign o_preprd[0] = rif.instr0_preprd;
    assign o_prd[1]  = rif.instr1_prd;   assign o_preprd[1] = rif.instr1_preprd;
    assign o_prd[2]  = rif.instr2_prd;   assign o_preprd[2] = rif.instr2_preprd;
    assign o_prd[3]  = rif.instr3_prd;   assign o_preprd[3] = rif.instr3_preprd;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_group(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_prs1_%0d", tag, k),   o_prs1[k],   e_prs1[k]);
            check($sformatf("%s_prs2_%0d", tag, k),   o_prs2[k],   e_prs2[k]);
            check($sformatf("%s_prd_%0d", tag, k),    o_prd[k],    e_prd[k]);
            check($sformatf("%s_preprd_%0d", tag, k), o_preprd[k], e_preprd[k]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = i;
        m_head = 0;
        for (int k = 0; k < 4; k++) begin
            e_prs1[k] = '0; e_prs2[k] = '0; e_prd[k] = '0; e_preprd[k] = '0;
        end
    endtask

    // Sequential renaming: each instruction reads its sources, then claims
    // a new register and updates the map, before the next one is considered.
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            e_prs1[k] = (g_v1[k] && g_rs1[k] != 0) ? 6'(m_rat[g_rs1[k]]) : 6'd0;
            e_prs2[k] = (g_v2[k] && g_rs2[k] != 0) ? 6'(m_rat[g_rs2[k]]) : 6'd0;
            if (g_vd[k] && g_rd[k] != 0) begin
                e_preprd[k]   = 6'(m_rat[g_rd[k]]);
                e_prd[k]      = 6'(32 + m_head);
                m_head        = (m_head + 1) % 32;
                m_rat[g_rd[k]] = 32 + ((m_head + 31) % 32);
            end else begin
                e_preprd[k] = '0;
                e_prd[k]    = '0;
            end
        end
    endtask

    task automatic drive();
        rif.instr0_rs1 = g_rs1[0]; rif.instr0_rs2 = g_rs2[0]; rif.instr0_rd = g_rd[0];
        rif.instr1_rs1 = g_rs1[1]; rif.instr1_rs2 = g_rs2[1]; rif.instr1_rd = g_rd[1];
        rif.instr2_rs1 = g_rs1[2]; rif.instr2_rs2 = g_rs2[2]; rif.instr2_rd = g_rd[2];
        rif.instr3_rs1 = g_rs1[3]; rif.instr3_rs2 = g_rs2[3]; rif.instr3_rd = g_rd[3];
        rif.instr_prs1_v = g_v1; rif.instr_prs2_v = g_v2; rif.instr_prd_v = g_vd;
    endtask

    task automatic set_instr(input int k, input int s1, input int s2, input int d);
        g_rs1[k] = 5'(s1); g_rs2[k] = 5'(s2); g_rd[k] = 5'(d);
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge clk);
        model_step();
        #1;
        check_group(tag);
    endtask

    // Reads every architectural register as a source without allocating,
    // exposing the full RAT through the renamed outputs.
    task automatic probe(input string tag);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) set_instr(k, 8*p + 2*k, 8*p + 2*k + 1, 0);
            g_v1 = 4'hF; g_v2 = 4'hF; g_vd = 4'h0;
            step(tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_group(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic full_group(input string tag);
        for (int k = 0; k < 4; k++) set_instr(k, $urandom_range(0, 31), $urandom_range(0, 31), k + 1);
        g_v1 = 4'hF; g_v2 = 4'hF; g_vd = 4'hF;
        step(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) set_instr(k, 0, 0, 0);
        g_v1 = '0; g_v2 = '0; g_vd = '0;
        drive();
        model_reset();
        #3;
        check_group("reset");
        @(negedge clk);
        rst = 1'b1;
        probe("id_probe");

        // WAW / RAW / WAR group, renamed twice.
        set_instr(0, 1, 2, 7); set_instr(1, 3, 7, 7); set_instr(2, 4, 6, 5); set_instr(3, 8, 9, 7);
        g_v1 = 4'hF; g_v2 = 4'hF; g_vd = 4'hF;
        step("waw1");
        check("waw1_prd0_lit", o_prd[0], 6'd32);
        check("waw1_prs2_1_lit", o_prs2[1], 6'd32);
        check("waw1_preprd3_lit", o_preprd[3], 6'd33);
        step("waw2");
        check("waw2_prs2_1_lit", o_prs2[1], 6'd36);
        check("waw2_preprd0_lit", o_preprd[0], 6'd35);
        check("waw2_preprd2_lit", o_preprd[2], 6'd34);
        probe("waw_probe");

        // Chain through R1.
        apply_reset("rst_chain");
        set_instr(0, 2, 3, 1); set_instr(1, 1, 4, 1); set_instr(2, 1, 5, 1); set_instr(3, 1, 6, 1);
        g_v1 = 4'hF; g_v2 = 4'hF; g_vd = 4'hF;
        step("chain");
        check("chain_prs1_3_lit", o_prs1[3], 6'd34);
        check("chain_preprd1_lit", o_preprd[1], 6'd32);
        probe("chain_probe");

        // Partial destination valid.
        set_instr(0, 10, 11, 10); set_instr(1, 12, 13, 11); set_instr(2, 10, 11, 12); set_instr(3, 12, 13, 13);
        g_vd = 4'b0101;
        step("partial");
        check("partial_prd2_lit", o_prd[2], 6'd37);
        check("partial_prd1_lit", o_prd[1], 6'd0);
        probe("partial_probe");

        // Wrap: eight full groups, then the ninth reuses P32.
        apply_reset("rst_wrap");
        for (int i = 0; i < 8; i++) full_group("fill");
        full_group("ninth");
        check("ninth_prd0_lit", o_prd[0], 6'd32);

        // R0 destinations allocate nothing, R0 sources read P0.
        for (int k = 0; k < 4; k++) set_instr(k, 0, k + 3, 0);
        g_v1 = 4'hF; g_v2 = 4'hF; g_vd = 4'hF;
        step("r0");
        check("r0_prs1_0_lit", o_prs1[0], 6'd0);
        full_group("after_r0");
        check("after_r0_prd0_lit", o_prd[0], 6'd36);

        // Bring fl_head to 30, then allocate four across the wrap.
        for (int i = 0; i < 5; i++) full_group("to30");
        for (int k = 0; k < 4; k++) set_instr(k, k, k, k + 20);
        g_vd = 4'b0011;
        step("to30_pair");
        full_group("wrap");
        check("wrap_prd0_lit", o_prd[0], 6'd62);
        check("wrap_prd1_lit", o_prd[1], 6'd63);
        check("wrap_prd2_lit", o_prd[2], 6'd32);
        check("wrap_prd3_lit", o_prd[3], 6'd33);
        probe("wrap_probe");

        // Random groups; half of them confined to R0..R7 to force collisions.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1)
                    set_instr(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                else
                    set_instr(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            end
            g_v1 = 4'($urandom_range(0, 15));
            g_v2 = 4'($urandom_range(0, 15));
            g_vd = 4'($urandom_range(0, 15));
            step("rand");
        end

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_group("async_rst");
        @(negedge clk);
        rst = 1'b1;
        probe("post_rst_probe");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
